// File: rtl/control_unit_if.sv
// control_unit_if: instruction word and register-transfer control lines between control_unit and datapath.
interface control_unit_if;
  logic [31:0] ir;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out;
  logic mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable;
  logic r15_enable, outport_enable, inport_enable, con_enable;
  logic pc_increment, read, ram_write, gra, grb, grc, r_in, r_out, run;
  modport master(
    input  ir,
    output pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out,
    output mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable,
    output r15_enable, outport_enable, inport_enable, con_enable,
    output pc_increment, read, ram_write, gra, grb, grc, r_in, r_out, run
  );
  modport slave(
    output ir,
    input  pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out, ba_out,
    input  mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable, lo_enable, hi_enable,
    input  r15_enable, outport_enable, inport_enable, con_enable,
    input  pc_increment, read, ram_write, gra, grb, grc, r_in, r_out, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for fetch, decode and execute of the load/store, I/O, move, nop and halt instructions.
module control_unit #(
  parameter int OPW = 5
) (
  input logic clk,
  input logic clr,
  control_unit_if.master cu
);
  typedef enum logic [4:0] {
    RESET, F0, F1, F2, DEC, LDI3, LDI4, LDI5, LD3, LD4, LD5, LD6, LD7,
    ST3, ST4, ST5, ST6, ST7, IN3, OUT3, MFHI3, MFLO3, HALT
  } state_t;
  state_t r_state, w_next;
  logic [OPW-1:0] w_op;
  logic w_unused;
  assign w_op = cu.ir[31 -: OPW];
  assign w_unused = ^cu.ir[31-OPW:0];
  always_ff @(posedge clk) r_state <= clr ? RESET : w_next;
  always_comb begin
    w_next = F0;
    case (r_state)
      F0:   w_next = F1;
      F1:   w_next = F2;
      F2:   w_next = DEC;
      DEC:
        case (w_op)
          OPW'(0):  w_next = LD3;
          OPW'(1):  w_next = LDI3;
          OPW'(2):  w_next = ST3;
          OPW'(21): w_next = IN3;
          OPW'(22): w_next = OUT3;
          OPW'(23): w_next = MFHI3;
          OPW'(24): w_next = MFLO3;
          OPW'(26): w_next = HALT;
          default:  w_next = F0;
        endcase
      LDI3: w_next = LDI4;
      LDI4: w_next = LDI5;
      LD3:  w_next = LD4;
      LD4:  w_next = LD5;
      LD5:  w_next = LD6;
      LD6:  w_next = LD7;
      ST3:  w_next = ST4;
      ST4:  w_next = ST5;
      ST5:  w_next = ST6;
      ST6:  w_next = ST7;
      HALT: w_next = HALT;
      default: w_next = F0;
    endcase
    // Outputs decode from r_state only, so ir never reaches them combinationally.
    cu.pc_out              = r_state == F0;
    cu.zlo_out             = r_state inside {F1, LDI5, LD5, ST5};
    cu.zhi_out             = 1'b0;
    cu.hi_out              = r_state == MFHI3;
    cu.lo_out              = r_state == MFLO3;
    cu.mdr_out             = r_state inside {F2, LD7};
    cu.inport_out          = r_state == IN3;
    cu.c_sign_extended_out = r_state inside {LDI4, LD4, ST4};
    cu.ba_out              = r_state inside {LDI3, LD3, ST3};
    cu.mar_enable          = r_state inside {F0, LD5, ST5};
    cu.z_enable            = r_state inside {F0, LDI4, LD4, ST4};
    cu.pc_enable           = r_state == F1;
    cu.mdr_enable          = r_state inside {F1, LD6, ST6};
    cu.ir_enable           = r_state == F2;
    cu.y_enable            = r_state inside {LDI3, LD3, ST3};
    cu.lo_enable           = 1'b0;
    cu.hi_enable           = 1'b0;
    cu.r15_enable          = 1'b0;
    cu.outport_enable      = r_state == OUT3;
    cu.inport_enable       = 1'b0;
    cu.con_enable          = 1'b0;
    cu.pc_increment        = r_state == F0;
    cu.read                = r_state inside {F1, LD6};
    cu.ram_write           = r_state == ST7;
    cu.gra                 = r_state inside {LDI5, LD7, ST6, IN3, OUT3, MFHI3, MFLO3};
    cu.grb                 = r_state inside {LDI3, LD3, ST3};
    cu.grc                 = 1'b0;
    cu.r_in                = r_state inside {LDI5, LD7, IN3, MFHI3, MFLO3};
    cu.r_out               = r_state inside {ST6, OUT3};
    cu.run                 = !(r_state inside {RESET, HALT});
  end
endmodule
